// File: rtl/loom_dataflow_pkg.sv
// Shared dataflow-fabric types and constants for the fork and its helpers.
package loom_dataflow_pkg;

    localparam int DATAFLOW_DEFAULT_WIDTH = 32;
    localparam int DATAFLOW_MAX_OUT       = 32;

    // Widest per-branch mask; users narrow it to their own branch count.
    typedef logic [DATAFLOW_MAX_OUT-1:0] branch_mask_t;

    // Mask with the low n branch bits set (the "every branch done" pattern).
    function automatic branch_mask_t branch_mask(input int n);
        branch_mask_t m;
        m = '0;
        for (int i = 0; i < DATAFLOW_MAX_OUT; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/dataflow_pipe_reg.sv
// One-entry valid/ready register. Full throughput: a new token may load in
// the same cycle the held token drains.
module dataflow_pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             buf_valid;
    logic [WIDTH-1:0] buf_data;

    // Accept when empty or when the held token leaves this cycle; never in reset.
    assign in_ready  = ~rst & (~buf_valid | out_ready);
    assign out_valid = buf_valid;
    assign out_data  = buf_data;

    // Occupancy flag: load wins over drain so back-to-back tokens keep flowing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        buf_valid <= 1'b0;
        else if (in_valid && in_ready)  buf_valid <= 1'b1;
        else if (out_ready)             buf_valid <= 1'b0;
    end

    // Payload needs no reset; it is only observed while buf_valid is set.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) buf_data <= in_data;
    end

endmodule

// File: rtl/dataflow_fork.sv
// Eager fork: one valid/ready token replicated to NUM_OUT branches, each of
// which may accept in a different cycle; the input retires once all have it.
// Optional input register: define LOOM_DATAFLOW_FORK_INBUF_EN.
module dataflow_fork
    import loom_dataflow_pkg::*;
#(
    parameter int WIDTH   = DATAFLOW_DEFAULT_WIDTH,
    parameter int NUM_OUT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data
);

    typedef logic [NUM_OUT-1:0] mask_t;
    localparam mask_t ALL_DONE = mask_t'(branch_mask(NUM_OUT));

    logic             core_valid;
    logic [WIDTH-1:0] core_data;
    logic             core_retire;
    mask_t            sent;
    mask_t            take;
    mask_t            done;

`ifdef LOOM_DATAFLOW_FORK_INBUF_EN
    // Registered front end: breaks the out_ready -> in_ready path when empty.
    dataflow_pipe_reg #(
        .WIDTH(WIDTH)
    ) u_inbuf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(core_valid),
        .out_ready(core_retire),
        .out_data (core_data)
    );
`else
    // Zero-latency: the core works straight off the producer. Reset masks the
    // token so nothing is offered or retired while rst is high.
    assign core_valid = in_valid & ~rst;
    assign core_data  = in_data;
    assign in_ready   = core_retire;
`endif

    // Fork core: offer to branches not yet served, retire when all are done.
    always_comb begin
        out_valid   = {NUM_OUT{core_valid}} & ~sent;
        take        = out_valid & out_ready;
        done        = sent | take;
        core_retire = core_valid & (done == ALL_DONE);
    end

    assign out_data = {NUM_OUT{core_data}};

    // Remember which branches already took the current token; clear on retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              sent <= '0;
        else if (core_retire) sent <= '0;
        else                  sent <= sent | take;
    end

endmodule
